miner_nonce_dispatcher: RTL and testbench
=========================================

Name: miner_nonce_dispatcher

Overview:
- Initiator side of the miner hashing interface.
- Accepts a mining job (block header, target, start nonce) and drives the multi-core hashing function one batch of NUM_CORES nonces at a time.
- Checks each batch result against the target and reports found / exhausted / timeout to the upstream controller through a valid/ready result handshake.

Parameters:
- NUM_CORES, 10, nonces per batch; must match the hashing function core count.
- TIMEOUT_CYCLES, 4096, watchdog limit per batch; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- job_valid  in  1  new job offered
- job_ready  out  1  dispatcher idle, job accepted when job_valid & job_ready
- job_block  in  608  block header, bit 0 MSB
- job_target  in  256  difficulty target, bit 0 MSB
- job_start_nonce  in  32  first nonce of the job
- abort  in  1  cancel the current job
- hash_enable  out  1  one-cycle batch start pulse to the hashing function
- nonce  out  32  batch base nonce; core i hashes nonce+i
- block  out  608  registered job block
- target  out  256  registered job target
- finished  in  1  hashing function batch complete
- correct_hash  in  256  winning hash, all-ones if none
- correct_nonce  in  32  winning nonce
- result_valid  out  1  result available
- result_ready  in  1  upstream consumes result
- result_status  out  2  FOUND=1, EXHAUSTED=2, TIMEOUT=3
- result_nonce  out  32  winning nonce, or 0
- result_hash  out  256  winning hash, or all-ones
- batches_done  out  32  batches checked for the current job, saturating

Behaviour:
- Reset values:
  - job_ready=1 and result_valid=0.
  - hash_enable=0, nonce=0, block=0, target=0.
  - result_status=0, result_nonce=0, result_hash=all-ones, batches_done=0.
  - FSM in IDLE.
- IDLE:
  - job_ready=1.
  - On job_valid: latch block, target and nonce=job_start_nonce, clear batches_done, go to ISSUE. Transition takes 1 cycle.
- ISSUE:
  - hash_enable=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - hash_enable=0; stay until finished=1.
  - finished seen in the same cycle as the pulse is ignored; it is sampled from the cycle after ISSUE.
- CHECK (1 cycle after finished):
  - batches_done increments, saturating at 0xFFFFFFFF.
  - Found when correct_hash <= target (unsigned 256-bit compare, bit 0 MSB). Latch correct_nonce/correct_hash and go to REPORT with FOUND.
  - Otherwise, compute a 33-bit sum nonce+NUM_CORES:
    - Carry set (wrap past 0xFFFFFFFF): go to REPORT with EXHAUSTED, result_nonce=0, result_hash=all-ones.
    - No carry: nonce takes the sum and the FSM returns to ISSUE.
- REPORT:
  - result_valid=1; all result outputs stay stable until result_ready.
  - On result_valid & result_ready: go to IDLE next cycle with result_valid=0.
- Abort:
  - In ISSUE/WAIT/CHECK, go to IDLE next cycle with no result and hash_enable forced low. A finished arriving afterwards is ignored.
  - abort in REPORT or IDLE has no effect.
  - When abort and finished arrive in the same cycle, abort wins.
- Job latency:
  - First hash_enable occurs 1 cycle after acceptance.
  - Back-to-back batches: ISSUE→WAIT→CHECK→ISSUE, minimum 3 cycles plus hashing latency.
- Reset mid-operation clears everything immediately and asynchronously; block/target/nonce return to 0.
- A job_valid arriving outside IDLE is not accepted (job_ready=0).

Optional Feature:
- Macro: MINER_DISPATCH_TIMEOUT_EN.
- Defined:
  - A 32-bit watchdog clears on each hash_enable and counts in WAIT.
  - When it reaches TIMEOUT_CYCLES without finished, go to REPORT with TIMEOUT, result_nonce=nonce (failing batch base), result_hash=all-ones.
- Not defined: no counter; WAIT holds indefinitely and TIMEOUT is never produced.

Decomposition:
- Package miner_pkg holds:
  - status enum (NONE=0, FOUND=1, EXHAUSTED=2, TIMEOUT=3);
  - FSM state enum;
  - width constants (BLOCK_W=608, HASH_W=256, NONCE_W=32);
  - HASH_NONE all-ones constant.
- One sub-module: miner_target_compare (combinational 256-bit unsigned less-or-equal), reusable by the cores.

Test Plan:
- Job with start_nonce=0x00000000, target=all-ones; finished stub returns correct_hash=0x00..01, correct_nonce=0x3:
  - one hash_enable pulse, then FOUND with result_nonce=0x3;
  - batches_done=1.
- Target=0; stub returns all-ones hash for three batches:
  - nonce sequence 0, 10, 20;
  - a fourth batch hash of 0 yields FOUND.
- start_nonce=0xFFFFFFF8, NUM_CORES=10, no hit:
  - exactly one batch, then EXHAUSTED, result_nonce=0, result_hash=all-ones.
- abort asserted in WAIT, then finished pulsed 2 cycles later:
  - back to IDLE, no result_valid, job_ready=1, hash_enable stays 0.
- FOUND with result_ready held low 5 cycles:
  - result_valid and all result fields stable; job_valid is not accepted until the handshake.
- With MINER_DISPATCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, finished never asserted:
  - TIMEOUT reported 16 cycles into WAIT with result_nonce equal to the batch base;
  - reset asserted mid-WAIT returns all outputs to reset values.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared types and constants for the miner nonce dispatcher.
// Vectors tagged "bit 0 MSB" are declared [0:W-1] so that index 0 is the
// most significant bit and plain relational operators give the unsigned order.
package miner_pkg;

  localparam int BLOCK_W = 608;
  localparam int HASH_W  = 256;
  localparam int NONCE_W = 32;

  // Value the hashing function reports when no core produced a winner
  localparam logic [0:HASH_W-1] HASH_NONE = '1;

  typedef enum logic [1:0] {
    STATUS_NONE      = 2'd0,
    STATUS_FOUND     = 2'd1,
    STATUS_EXHAUSTED = 2'd2,
    STATUS_TIMEOUT   = 2'd3
  } status_t;

  typedef enum logic [2:0] {
    FSM_IDLE   = 3'd0,
    FSM_ISSUE  = 3'd1,
    FSM_WAIT   = 3'd2,
    FSM_CHECK  = 3'd3,
    FSM_REPORT = 3'd4
  } fsm_t;

endpackage

// File: rtl/miner_target_compare.sv
// Combinational unsigned "hash <= target" test on 256-bit big-endian values
// (index 0 is the MSB). Kept separate so the hashing cores can reuse it.
import miner_pkg::*;

module miner_target_compare (
  input  logic [0:HASH_W-1] i_hash,
  input  logic [0:HASH_W-1] i_target,
  output logic              o_le
);

  // Unsigned magnitude compare; the [0:N] declaration already orders bit 0 as MSB
  always_comb begin
    o_le = (i_hash <= i_target);
  end

endmodule

// File: rtl/miner_nonce_dispatcher.sv
// Initiator side of the miner hashing interface: accepts a job, issues
// batches of NUM_CORES nonces to the hashing function, checks each batch
// result against the target and reports FOUND / EXHAUSTED / TIMEOUT.
// Optional watchdog: define MINER_DISPATCH_TIMEOUT_EN to enable the
// per-batch TIMEOUT_CYCLES watchdog; without it WAIT holds indefinitely.
//
// Handshakes: a job transfers on a cycle where job_valid & job_ready are both
// high; a result transfers on a cycle where result_valid & result_ready are
// both high. A valid, once raised, holds its payload stable until the transfer.
import miner_pkg::*;

module miner_nonce_dispatcher #(
  parameter int NUM_CORES      = 10,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [0:BLOCK_W-1]    job_block,
  input  logic [0:HASH_W-1]     job_target,
  input  logic [NONCE_W-1:0]    job_start_nonce,
  input  logic                  abort,
  output logic                  hash_enable,
  output logic [NONCE_W-1:0]    nonce,
  output logic [0:BLOCK_W-1]    block,
  output logic [0:HASH_W-1]     target,
  input  logic                  finished,
  input  logic [0:HASH_W-1]     correct_hash,
  input  logic [NONCE_W-1:0]    correct_nonce,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [1:0]            result_status,
  output logic [NONCE_W-1:0]    result_nonce,
  output logic [0:HASH_W-1]     result_hash,
  output logic [31:0]           batches_done,
  output logic [2:0]            dbg_state
);

  localparam logic [2:0] S_IDLE   = FSM_IDLE;
  localparam logic [2:0] S_ISSUE  = FSM_ISSUE;
  localparam logic [2:0] S_WAIT   = FSM_WAIT;
  localparam logic [2:0] S_CHECK  = FSM_CHECK;
  localparam logic [2:0] S_REPORT = FSM_REPORT;

  logic [2:0]         r_state;
  logic [NONCE_W-1:0] r_nonce;
  logic [0:BLOCK_W-1] r_block;
  logic [0:HASH_W-1]  r_target;
  logic [0:HASH_W-1]  r_cand_hash;
  logic [NONCE_W-1:0] r_cand_nonce;
  logic [1:0]         r_status;
  logic [NONCE_W-1:0] r_res_nonce;
  logic [0:HASH_W-1]  r_res_hash;
  logic [31:0]        r_batches;
  logic               w_found;
  logic [NONCE_W:0]   w_next_sum;

`ifdef MINER_DISPATCH_TIMEOUT_EN
  localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0]        r_wdog;
`endif

  // Winner test on the result captured when finished was seen
  miner_target_compare u_cmp (
    .i_hash   (r_cand_hash),
    .i_target (r_target),
    .o_le     (w_found)
  );

  // Next batch base; the extra top bit flags a wrap past 0xFFFFFFFF
  always_comb begin
    w_next_sum = {1'b0, r_nonce} + (NONCE_W + 1)'(NUM_CORES);
  end

  // Output decode; abort suppresses a start pulse in the same cycle
  always_comb begin
    job_ready     = (r_state == S_IDLE);
    hash_enable   = (r_state == S_ISSUE) && !abort;
    result_valid  = (r_state == S_REPORT);
    nonce         = r_nonce;
    block         = r_block;
    target        = r_target;
    result_status = r_status;
    result_nonce  = r_res_nonce;
    result_hash   = r_res_hash;
    batches_done  = r_batches;
    dbg_state     = r_state;
  end

  // Dispatcher FSM with job, batch and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_nonce      <= '0;
      r_block      <= '0;
      r_target     <= '0;
      r_cand_hash  <= HASH_NONE;
      r_cand_nonce <= '0;
      r_status     <= STATUS_NONE;
      r_res_nonce  <= '0;
      r_res_hash   <= HASH_NONE;
      r_batches    <= '0;
`ifdef MINER_DISPATCH_TIMEOUT_EN
      r_wdog       <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (job_valid) begin
            r_block     <= job_block;
            r_target    <= job_target;
            r_nonce     <= job_start_nonce;
            r_batches   <= '0;
            r_status    <= STATUS_NONE;
            r_res_nonce <= '0;
            r_res_hash  <= HASH_NONE;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else begin
`ifdef MINER_DISPATCH_TIMEOUT_EN
            r_wdog  <= '0;
`endif
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else if (finished) begin
            r_cand_hash  <= correct_hash;
            r_cand_nonce <= correct_nonce;
            r_state      <= S_CHECK;
          end
`ifdef MINER_DISPATCH_TIMEOUT_EN
          else if (r_wdog == WDOG_LAST) begin
            r_status    <= STATUS_TIMEOUT;
            r_res_nonce <= r_nonce;
            r_res_hash  <= HASH_NONE;
            r_state     <= S_REPORT;
          end else begin
            r_wdog <= r_wdog + 32'd1;
          end
`endif
        end
        S_CHECK: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else begin
            if (r_batches != '1) begin
              r_batches <= r_batches + 32'd1;
            end
            if (w_found) begin
              r_status    <= STATUS_FOUND;
              r_res_nonce <= r_cand_nonce;
              r_res_hash  <= r_cand_hash;
              r_state     <= S_REPORT;
            end else if (w_next_sum[NONCE_W]) begin
              r_status    <= STATUS_EXHAUSTED;
              r_res_nonce <= '0;
              r_res_hash  <= HASH_NONE;
              r_state     <= S_REPORT;
            end else begin
              r_nonce <= w_next_sum[NONCE_W-1:0];
              r_state <= S_ISSUE;
            end
          end
        end
        S_REPORT: begin
          if (result_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_miner_nonce_dispatcher.sv
// Directed bench for miner_nonce_dispatcher: a table of single-batch jobs
// plus hand-written sequences for multi-batch, abort, back-pressure, reset
// and the optional watchdog (MINER_DISPATCH_TIMEOUT_EN).
module tb_miner_nonce_dispatcher;

  logic               clk = 1'b0;
  logic               rst;
  logic               job_valid;
  logic               job_ready;
  logic [0:607]       job_block;
  logic [0:255]       job_target;
  logic [31:0]        job_start_nonce;
  logic               abort;
  logic               hash_enable;
  logic [31:0]        nonce;
  logic [0:607]       block;
  logic [0:255]       target;
  logic               finished;
  logic [0:255]       correct_hash;
  logic [31:0]        correct_nonce;
  logic               result_valid;
  logic               result_ready;
  logic [1:0]         result_status;
  logic [31:0]        result_nonce;
  logic [0:255]       result_hash;
  logic [31:0]        batches_done;
  logic [2:0]         dbg_state;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [0:255] ONES = '1;

  typedef struct {
    logic [31:0]  start;
    logic [0:255] tgt;
    logic [0:255] hash;
    logic [31:0]  win;
    logic [1:0]   exp_status;
    logic [31:0]  exp_nonce;
    logic [0:255] exp_hash;
  } vec_t;

  vec_t vecs[5];

  // Clock and DUT
  always #5 clk = ~clk;

  miner_nonce_dispatcher #(.NUM_CORES(10), .TIMEOUT_CYCLES(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .job_valid       (job_valid),
    .job_ready       (job_ready),
    .job_block       (job_block),
    .job_target      (job_target),
    .job_start_nonce (job_start_nonce),
    .abort           (abort),
    .hash_enable     (hash_enable),
    .nonce           (nonce),
    .block           (block),
    .target          (target),
    .finished        (finished),
    .correct_hash    (correct_hash),
    .correct_nonce   (correct_nonce),
    .result_valid    (result_valid),
    .result_ready    (result_ready),
    .result_status   (result_status),
    .result_nonce    (result_nonce),
    .result_hash     (result_hash),
    .batches_done    (batches_done),
    .dbg_state       (dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [607:0] act, input logic [607:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Offer a job from IDLE; the first start pulse must follow one cycle later
  task automatic send_job(input logic [31:0] s, input logic [0:255] t, input logic [0:607] b);
    check("job_ready_idle", job_ready, 1);
    job_valid = 1'b1; job_start_nonce = s; job_target = t; job_block = b;
    tick();
    job_valid = 1'b0;
    check("first_pulse_latency", hash_enable, 1);
    check("block_latched", block, b);
    check("target_latched", target, t);
  endtask

  // Hashing stub: wait for a start pulse, then return one batch result
  task automatic do_batch(input logic [0:255] h, input logic [31:0] w, output logic [31:0] base);
    for (int i = 0; i < 10 && hash_enable !== 1'b1; i++) tick();
    check("batch_pulse", hash_enable, 1);
    base = nonce;
    tick();
    check("pulse_one_cycle", hash_enable, 0);
    tick();
    finished = 1'b1; correct_hash = h; correct_nonce = w;
    tick();
    finished = 1'b0; correct_hash = '1; correct_nonce = '0;
  endtask

  task automatic wait_result();
    for (int i = 0; i < 10 && result_valid !== 1'b1; i++) tick();
    check("result_valid_up", result_valid, 1);
  endtask

  task automatic handshake();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("result_valid_down", result_valid, 0);
    check("job_ready_after", job_ready, 1);
  endtask

  initial begin
    logic [31:0]  base;
    logic [0:607] blk;
    bit           saw_he, saw_rv;
    int           cnt;

    vecs[0] = '{32'h0000_0000, ONES,  256'h1,   32'h3,    2'd1, 32'h3,    256'h1};
    vecs[1] = '{32'h0000_1000, 256'hFF, 256'hFF, 32'h1005, 2'd1, 32'h1005, 256'hFF};
    vecs[2] = '{32'hFFFF_FFF8, 256'hFF, 256'h100, 32'h1234, 2'd2, 32'h0,  ONES};
    vecs[3] = '{32'hFFFF_FFF6, 256'h0, ONES,     32'h0,    2'd2, 32'h0,    ONES};
    vecs[4] = '{32'h0000_0020, {1'b1, 255'b0}, {1'b0, {255{1'b1}}}, 32'h27, 2'd1, 32'h27,
                {1'b0, {255{1'b1}}}};

    rst = 1'b1; job_valid = 1'b0; job_block = '0; job_target = '0; job_start_nonce = '0;
    abort = 1'b0; finished = 1'b0; correct_hash = '1; correct_nonce = '0; result_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_job_ready", job_ready, 1);
    check("rst_result_valid", result_valid, 0);
    check("rst_hash_enable", hash_enable, 0);
    check("rst_nonce", nonce, 0);
    check("rst_block", block, 0);
    check("rst_target", target, 0);
    check("rst_status", result_status, 0);
    check("rst_res_nonce", result_nonce, 0);
    check("rst_res_hash", result_hash, ONES);
    check("rst_batches", batches_done, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    tick();

    // Single-batch jobs: hits, the <= boundary, and both exhaust boundaries
    for (int v = 0; v < 5; v++) begin
      blk = {19{32'hA5A5_0000 + 32'(v)}};
      send_job(vecs[v].start, vecs[v].tgt, blk);
      do_batch(vecs[v].hash, vecs[v].win, base);
      check($sformatf("v%0d_base", v), base, vecs[v].start);
      wait_result();
      check($sformatf("v%0d_status", v), result_status, vecs[v].exp_status);
      check($sformatf("v%0d_nonce", v), result_nonce, vecs[v].exp_nonce);
      check($sformatf("v%0d_hash", v), result_hash, vecs[v].exp_hash);
      check($sformatf("v%0d_batches", v), batches_done, 1);
      handshake();
    end

    // Target 0: three misses then a zero hash; bases step by 10
    blk = {19{32'h1111_2222}};
    send_job(32'h0, 256'h0, blk);
    for (int k = 0; k < 4; k++) begin
      do_batch((k < 3) ? ONES : 256'h0, 32'h21, base);
      check($sformatf("multi_base%0d", k), base, 32'(k * 10));
    end
    wait_result();
    check("multi_status", result_status, 1);
    check("multi_nonce", result_nonce, 32'h21);
    check("multi_hash", result_hash, 0);
    check("multi_batches", batches_done, 4);
    handshake();

    // Abort in WAIT, then a late finished must be ignored
    send_job(32'h100, 256'h0, blk);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_job_ready", job_ready, 1);
    check("abort_no_result", result_valid, 0);
    tick();
    finished = 1'b1; correct_hash = '0;
    tick();
    finished = 1'b0; correct_hash = '1;
    saw_he = 1'b0; saw_rv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      saw_he |= hash_enable; saw_rv |= result_valid;
      tick();
    end
    check("abort_late_he", saw_he, 0);
    check("abort_late_rv", saw_rv, 0);
    check("abort_idle", job_ready, 1);

    // Abort and finished together: abort wins
    send_job(32'h200, ONES, blk);
    tick();
    abort = 1'b1; finished = 1'b1; correct_hash = '0;
    tick();
    abort = 1'b0; finished = 1'b0; correct_hash = '1;
    check("abort_fin_idle", job_ready, 1);
    tick();
    check("abort_fin_no_result", result_valid, 0);

    // Result held under back-pressure; new job refused until the handshake
    send_job(32'h50, ONES, blk);
    do_batch(256'h1, 32'h55, base);
    wait_result();
    job_valid = 1'b1; job_start_nonce = 32'h999;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", result_valid, 1);
      check("stall_status", result_status, 1);
      check("stall_nonce", result_nonce, 32'h55);
      check("stall_hash", result_hash, 256'h1);
      check("stall_job_ready", job_ready, 0);
      check("stall_base", nonce, 32'h50);
    end
    job_valid = 1'b0;
    handshake();

    // Asynchronous reset in WAIT
    send_job(32'hDEAD_0000, 256'hABCD, {19{32'h5A5A_C3C3}});
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("mrst_job_ready", job_ready, 1);
    check("mrst_hash_enable", hash_enable, 0);
    check("mrst_nonce", nonce, 0);
    check("mrst_block", block, 0);
    check("mrst_target", target, 0);
    check("mrst_res_hash", result_hash, ONES);
    check("mrst_batches", batches_done, 0);
    check("mrst_valid", result_valid, 0);
    rst = 1'b0;
    tick();

`ifdef MINER_DISPATCH_TIMEOUT_EN
    // Watchdog: no finished, TIMEOUT 16 cycles into WAIT
    send_job(32'h700, 256'h0, blk);
    tick();
    cnt = 0;
    while (result_valid !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    check("to_cycles", cnt, 16);
    check("to_status", result_status, 3);
    check("to_nonce", result_nonce, 32'h700);
    check("to_hash", result_hash, ONES);
    handshake();
`else
    // Without the watchdog WAIT holds indefinitely
    send_job(32'h700, 256'h0, blk);
    tick();
    saw_rv = 1'b0;
    for (int i = 0; i < 50; i++) begin
      saw_rv |= result_valid;
      tick();
    end
    check("hold_no_result", saw_rv, 0);
    check("hold_in_wait", dbg_state, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("hold_abort_idle", job_ready, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global bound on run time
  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench time limit");
  end

endmodule
